// File: rtl/seq_mult4.sv
// ---------------------------------------------------------------------------
// seq_mult4 -- sequential shift-add unsigned multiplier controller.
//
// The arithmetic itself lives in one external WIDTH-bit ripple-carry adder
// (CPA). This block drives the CPA operands from its own registers and, on
// every RUN cycle, registers the CPA sum and carry-out back into the
// accumulator while shifting the {A,Q} pair right. After WIDTH RUN cycles the
// 2*WIDTH-bit product sits in {A,Q}. It is then copied to p and done pulses.
//
// Ports
//   clk        in   1        rising-edge clock
//   reset_n    in   1        asynchronous active-low reset
//   start      in   1        operation request, looked at only in IDLE
//   a          in   WIDTH    multiplicand, captured on an accepted start
//   b          in   WIDTH    multiplier, captured on an accepted start
//   busy       out  1        high while the multiply is running
//   done       out  1        one-cycle pulse; p is valid from this cycle on
//   p          out  2*WIDTH  product register, held until the next completion
//   cpa_a      out  WIDTH    CPA operand a: accumulator A
//   cpa_b      out  WIDTH    CPA operand b: Q[0] ? M : 0
//   cpa_cin    out  1        CPA carry-in, tied to 0
//   cpa_s      in   WIDTH    CPA sum
//   cpa_cout   in   1        CPA carry-out
//   dbg_state  out  2        current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Handshake: a request is a cycle with start=1 while busy=0 and done=0, which
// means the FSM is in IDLE. That cycle's clock edge accepts it and captures a
// and b. There is no ready signal and no queue. A start seen in RUN or DONE is
// dropped. The result is announced by a single done cycle and stays on p.
// ---------------------------------------------------------------------------
module seq_mult4 #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output logic [WIDTH-1:0]   cpa_a,
  output logic [WIDTH-1:0]   cpa_b,
  output logic               cpa_cin,
  input  logic [WIDTH-1:0]   cpa_s,
  input  logic               cpa_cout,
  output logic [1:0]         dbg_state
);

  // cnt must hold the value WIDTH itself, so it needs one bit beyond clog2.
  localparam int              CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   acc;    // accumulator A (high product half)
  logic [WIDTH-1:0]   mq;     // multiplier Q, becomes the low product half
  logic [WIDTH-1:0]   mcand;  // multiplicand M
  logic [CW-1:0]      cnt;    // RUN cycles remaining

  // Add-and-shift result: the carry-out becomes the new top bit of A.
  // Every bit of the sum is kept, so no carry is ever lost.
  logic [2*WIDTH-1:0] shifted;
  assign shifted = {cpa_cout, cpa_s, mq[WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      acc   <= '0;
      mq    <= '0;
      mcand <= '0;
      cnt   <= '0;
      p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            mq    <= b;
            acc   <= '0;
            cnt   <= CNT_INIT;
            state <= RUN;
          end
        end
        RUN: begin
          {acc, mq} <= shifted;
          cnt       <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            p     <= shifted;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status outputs and CPA operands come only from registers, so they are
  // glitch-free and have no combinational path from start, a or b.
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

  assign cpa_a   = acc;
  assign cpa_b   = mq[0] ? mcand : '0;
  assign cpa_cin = 1'b0;

endmodule

// File: tb/tb_seq_mult4.sv
module tb_seq_mult4;

  localparam int W = 4;

  logic           clk;
  logic           reset_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;
  logic [W-1:0]   cpa_a;
  logic [W-1:0]   cpa_b;
  logic           cpa_cin;
  logic [W-1:0]   cpa_s;
  logic           cpa_cout;
  logic [1:0]     dbg_state;

  // Behavioural stand-in for the external 4-bit ripple-carry adder.
  logic [W:0] cpa_sum;
  assign cpa_sum  = {1'b0, cpa_a} + {1'b0, cpa_b} + {{W{1'b0}}, cpa_cin};
  assign cpa_s    = cpa_sum[W-1:0];
  assign cpa_cout = cpa_sum[W];

  seq_mult4 #(.WIDTH(W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .p(p),
    .cpa_a(cpa_a),
    .cpa_b(cpa_b),
    .cpa_cin(cpa_cin),
    .cpa_s(cpa_s),
    .cpa_cout(cpa_cout),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation: pulse start, count busy cycles, wait (bounded) for
  // done, compare p against the queued expectation, confirm done was a
  // single-cycle pulse. Returns in the cycle right after done.
  task automatic do_mult(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [2*W-1:0] exp_p, input string name);
    int nb;
    int cyc;
    logic [2*W-1:0] e;
    exp_q.push_back(exp_p);
    start = 1'b1;
    a     = x;
    b     = y;
    step();
    start = 1'b0;
    nb  = 0;
    cyc = 0;
    while (!done && cyc < 20) begin
      if (busy) nb++;
      step();
      cyc++;
    end
    check({name, " done seen"}, 32'(done), 32'd1);
    check({name, " busy cycles"}, 32'(nb), 32'(W));
    e = exp_q.pop_front();
    check({name, " p"}, 32'(p), 32'(e));
    step();
    check({name, " done single pulse"}, 32'(done), 32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic [2*W-1:0] vp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int nd;
    int nbusy;
    logic [2*W-1:0] pcap;

    vecs[0]  = '{4'd7,  4'd9,  8'h3F};
    vecs[1]  = '{4'd15, 4'd15, 8'hE1};
    vecs[2]  = '{4'd0,  4'd13, 8'h00};
    vecs[3]  = '{4'd13, 4'd0,  8'h00};
    vecs[4]  = '{4'd5,  4'd6,  8'h1E};
    vecs[5]  = '{4'd11, 4'd12, 8'h84};
    vecs[6]  = '{4'd1,  4'd1,  8'h01};
    vecs[7]  = '{4'd15, 4'd1,  8'h0F};
    vecs[8]  = '{4'd1,  4'd15, 8'h0F};
    vecs[9]  = '{4'd8,  4'd8,  8'h40};
    vecs[10] = '{4'd10, 4'd5,  8'h32};
    vecs[11] = '{4'd3,  4'd3,  8'h09};

    start   = 1'b0;
    a       = '0;
    b       = '0;
    reset_n = 1'b0;

    // 1. reset state, then idle with reset released
    step();
    check("reset p", 32'(p), 32'h00);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle p", 32'(p), 32'h00);
      check("idle busy", 32'(busy), 32'd0);
      check("idle done", 32'(done), 32'd0);
    end

    // 2. 7x9 and hold of p over idle cycles
    do_mult(4'd7, 4'd9, 8'h3F, "7x9");
    for (int i = 0; i < 5; i++) begin
      check("p hold", 32'(p), 32'h3F);
      check("cpa_cin", 32'(cpa_cin), 32'd0);
      step();
    end

    // 3/6. table vectors, including back-to-back 5x6 then 11x12
    for (int i = 0; i < 12; i++) begin
      do_mult(vecs[i].va, vecs[i].vb, vecs[i].vp, $sformatf("vec%0d", i));
    end

    // 4. start and operand changes during RUN are ignored
    start = 1'b1; a = 4'd7; b = 4'd9;
    step();
    start = 1'b1; a = 4'd3; b = 4'd3;
    step();
    a = 4'd2; b = 4'd14;
    step();
    start = 1'b0; a = 4'd15; b = 4'd1;
    nd = 0;
    nbusy = 0;
    pcap = '0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        nd++;
        pcap = p;
      end
      if (busy) nbusy++;
      step();
    end
    check("run-start done count", 32'(nd), 32'd1);
    check("run-start p", 32'(pcap), 32'h3F);
    check("run-start p held", 32'(p), 32'h3F);
    check("run-start busy tail", 32'(nbusy), 32'd2);

    // start presented only during DONE is dropped
    start = 1'b1; a = 4'd7; b = 4'd3;
    step();
    start = 1'b0;
    nd = 0;
    while (!done && nd < 20) begin
      step();
      nd++;
    end
    check("done-start done seen", 32'(done), 32'd1);
    start = 1'b1; a = 4'd2; b = 4'd2;
    step();
    start = 1'b0;
    check("done-start not accepted", 32'(busy), 32'd0);
    step();
    check("done-start still idle", 32'(busy), 32'd0);
    check("done-start p", 32'(p), 32'h15);

    // 5. reset mid-RUN aborts immediately, no done afterwards
    start = 1'b1; a = 4'd15; b = 4'd15;
    step();
    start = 1'b0;
    step();
    check("pre-abort busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort p", 32'(p), 32'h00);
    check("abort done", 32'(done), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    nd = 0;
    nbusy = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done) nd++;
      if (busy) nbusy++;
    end
    check("post-abort done count", 32'(nd), 32'd0);
    check("post-abort busy count", 32'(nbusy), 32'd0);
    check("post-abort p", 32'(p), 32'h00);

    // 6. exhaustive sweep against a reference multiply
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        do_mult(W'(x), W'(y), 8'(x * y), $sformatf("sweep %0dx%0d", x, y));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
